irq_controller: RTL and testbench

Parametrised interrupt controller between the SoC peripherals and the CPU control unit. It replaces the fixed four-line interrupt hookup with:
- NUM_IRQ request channels, each selectable as edge or level triggered;
- per-channel masking and fixed priority;
- nested in-service tracking;
- a registered request/acknowledge handshake that delivers a stable vector address and a one-cycle clear pulse back to the requesting peripheral.

---
 rtl/irq_controller.sv | 168 ++++++++++++++++
 tb/tb_irq_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//
// Parametrised interrupt controller sitting between SoC peripherals and the
// CPU control unit. Each channel can capture rising edges or follow a level.
// Channels are masked per line and globally. Lower channel numbers have higher
// priority. Nested in-service tracking blocks equal- and lower-priority
// channels while a handler runs. A registered request/acknowledge handshake
// presents a stable vector address. Acknowledge also sends a one-cycle clear
// pulse back to the peripheral that was served.
//
// Ports
//   clk             system clock, rising edge
//   reset           synchronous, active-high reset
//   irq_in          raw request lines (already synchronous to clk)
//   irq_edge_mode   per channel: 1 = rising-edge capture, 0 = level
//   irq_mask        per channel: 1 = enabled
//   global_ie       CPU interrupt-enable flag
//   irq_req         registered request to the control unit
//   irq_id          latched channel number of current/last request
//   irq_vector      latched vector address
//   irq_ack         one-cycle pulse: CPU takes the vector
//   irq_clr         one-hot, one-cycle clear pulse to the acknowledged channel
//   irq_eoi         one-cycle end-of-interrupt pulse
//   irq_pending     pending register
//   irq_in_service  in-service register
//   irq_active      OR-reduction of irq_in_service
// -----------------------------------------------------------------------------
module irq_controller #(
  parameter int                    NUM_IRQ       = 4,
  parameter int                    ADDR_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE   = 16'h0004,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_STRIDE = 16'h0004,
  localparam int                   ID_WIDTH      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic [NUM_IRQ-1:0]    irq_edge_mode,
  input  logic [NUM_IRQ-1:0]    irq_mask,
  input  logic                  global_ie,
  output logic                  irq_req,
  output logic [ID_WIDTH-1:0]   irq_id,
  output logic [ADDR_WIDTH-1:0] irq_vector,
  input  logic                  irq_ack,
  output logic [NUM_IRQ-1:0]    irq_clr,
  input  logic                  irq_eoi,
  output logic [NUM_IRQ-1:0]    irq_pending,
  output logic [NUM_IRQ-1:0]    irq_in_service,
  output logic                  irq_active
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [NUM_IRQ-1:0]    r_prev;
  logic [NUM_IRQ-1:0]    r_pending;
  logic [NUM_IRQ-1:0]    r_in_service;
  logic [NUM_IRQ-1:0]    r_clr;
  logic                  r_req;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_vector;

  logic [NUM_IRQ-1:0]    w_allow;
  logic [NUM_IRQ-1:0]    w_eligible;
  logic [NUM_IRQ-1:0]    w_id_onehot;
  logic [NUM_IRQ-1:0]    w_pending_next;
  logic [NUM_IRQ-1:0]    w_eoi_cleared;
  logic [NUM_IRQ-1:0]    w_in_service_next;
  logic [ID_WIDTH-1:0]   w_winner;
  logic [ADDR_WIDTH-1:0] w_vector;
  logic                  w_any;
  logic                  w_take;
  logic                  w_latch;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
      // A channel may interrupt only if no in-service bit exists at its own
      // index or any higher-priority (lower) index.
      assign w_allow[gi]     = ~|r_in_service[gi:0];
      assign w_id_onehot[gi] = (r_id == ID_WIDTH'(gi));
      // Edge channels: a new edge wins over a same-cycle acknowledge clear.
      // Level channels simply track the line.
      assign w_pending_next[gi] = irq_edge_mode[gi]
          ? ((irq_in[gi] & ~r_prev[gi]) | (r_pending[gi] & ~(w_take & w_id_onehot[gi])))
          : irq_in[gi];
    end
  endgenerate

  assign w_eligible = r_pending & irq_mask & {NUM_IRQ{global_ie}} & w_allow;
  assign w_any      = |w_eligible;

  // Lowest eligible index wins; scanning downward leaves the lowest one last.
  always_comb begin
    w_winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_winner = ID_WIDTH'(i);
    end
  end

  assign w_vector = VECTOR_BASE + ADDR_WIDTH'(w_winner) * VECTOR_STRIDE;

  // EOI retires the highest-priority handler (lowest set bit); the ack set is
  // applied on top so a same-cycle EOI and ack both take effect.
  assign w_eoi_cleared     = irq_eoi ? (r_in_service & (r_in_service - NUM_IRQ'(1)))
                                     : r_in_service;
  assign w_in_service_next = w_eoi_cleared | (w_take ? w_id_onehot : '0);

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_next = S_REQ;
          w_latch      = 1'b1;
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          w_state_next = S_IDLE;
          w_take       = 1'b1;
        end else if (~|(w_eligible & w_id_onehot)) begin
          // Latched channel lost eligibility: withdraw quietly.
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // prev follows the line even in reset so a line already high at release
    // does not look like an edge.
    r_prev <= irq_in;
    if (reset) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_in_service <= '0;
      r_req        <= 1'b0;
      r_clr        <= '0;
      r_id         <= '0;
      r_vector     <= VECTOR_BASE;
    end else begin
      r_state      <= w_state_next;
      r_pending    <= w_pending_next;
      r_in_service <= w_in_service_next;
      r_req        <= (w_state_next == S_REQ);
      r_clr        <= w_take ? w_id_onehot : '0;
      if (w_latch) begin
        r_id     <= w_winner;
        r_vector <= w_vector;
      end
    end
  end

  assign irq_req        = r_req;
  assign irq_id         = r_id;
  assign irq_vector     = r_vector;
  assign irq_clr        = r_clr;
  assign irq_pending    = r_pending;
  assign irq_in_service = r_in_service;
  assign irq_active     = |r_in_service;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] vec;
    int          cyc;
  } req_t;

  typedef struct packed {
    logic [3:0] clr;
    logic [3:0] is;
  } ack_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_in = '0;
  logic [3:0]  irq_edge_mode = 4'hF;
  logic [3:0]  irq_mask = 4'hF;
  logic        global_ie = 1'b1;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic [15:0] irq_vector;
  logic        irq_ack = 1'b0;
  logic [3:0]  irq_clr;
  logic        irq_eoi = 1'b0;
  logic [3:0]  irq_pending;
  logic [3:0]  irq_in_service;
  logic        irq_active;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  logic prev_req = 1'b0;
  req_t exp_req_q[$];
  ack_t exp_ack_q[$];

  irq_controller dut (
    .clk            (clk),
    .reset          (reset),
    .irq_in         (irq_in),
    .irq_edge_mode  (irq_edge_mode),
    .irq_mask       (irq_mask),
    .global_ie      (global_ie),
    .irq_req        (irq_req),
    .irq_id         (irq_id),
    .irq_vector     (irq_vector),
    .irq_ack        (irq_ack),
    .irq_clr        (irq_clr),
    .irq_eoi        (irq_eoi),
    .irq_pending    (irq_pending),
    .irq_in_service (irq_in_service),
    .irq_active     (irq_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %-22s got %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT raises a request or
  // emits a clear pulse.
  always @(negedge clk) begin
    if (irq_req && !prev_req) begin
      if (exp_req_q.size() == 0) begin
        check("unexpected_req", {30'd0, irq_id}, 32'hFFFF_FFFF);
      end else begin
        req_t e;
        e = exp_req_q.pop_front();
        check("req_id", {30'd0, irq_id}, {30'd0, e.id});
        check("req_vector", {16'd0, irq_vector}, {16'd0, e.vec});
        check("req_cycle", cyc, e.cyc);
      end
    end
    if (irq_clr != 4'b0000) begin
      if (exp_ack_q.size() == 0) begin
        check("unexpected_clr", {28'd0, irq_clr}, 32'd0);
      end else begin
        ack_t a;
        a = exp_ack_q.pop_front();
        check("ack_clr", {28'd0, irq_clr}, {28'd0, a.clr});
        check("ack_in_service", {28'd0, irq_in_service}, {28'd0, a.is});
      end
    end
    prev_req <= irq_req;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input logic [1:0] id, input logic [15:0] vec, input int lat);
    req_t r;
    r.id  = id;
    r.vec = vec;
    r.cyc = cyc + lat;
    exp_req_q.push_back(r);
  endtask

  task automatic do_ack(input logic [3:0] clr, input logic [3:0] is);
    ack_t a;
    a.clr = clr;
    a.is  = is;
    exp_ack_q.push_back(a);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    irq_eoi = 1'b1;
    step();
    irq_eoi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    step(3);
    reset = 1'b0;
    check("rst_req", {31'd0, irq_req}, 32'd0);
    check("rst_id", {30'd0, irq_id}, 32'd0);
    check("rst_vector", {16'd0, irq_vector}, 32'h0004);
    check("rst_pending", {28'd0, irq_pending}, 32'd0);
    check("rst_in_service", {28'd0, irq_in_service}, 32'd0);
    check("rst_clr", {28'd0, irq_clr}, 32'd0);
    step();

    // Edge on channel 2
    irq_in[2] = 1'b1;
    expect_req(2'd2, 16'h000C, 2);
    step();
    check("t1_pending", {28'd0, irq_pending}, 32'h4);
    step();
    do_ack(4'b0100, 4'b0100);
    check("t1_pending_clr", {28'd0, irq_pending}, 32'h0);
    check("t1_req_low", {31'd0, irq_req}, 32'd0);
    check("t1_active", {31'd0, irq_active}, 32'd1);
    step();
    check("t1_clr_one_cycle", {28'd0, irq_clr}, 32'd0);
    irq_in[2] = 1'b0;
    do_eoi();
    check("t1_eoi", {28'd0, irq_in_service}, 32'd0);
    step();

    // Simultaneous edges on channels 1 and 3
    irq_in = 4'b1010;
    expect_req(2'd1, 16'h0008, 2);
    step(2);
    do_ack(4'b0010, 4'b0010);
    check("t2_ch3_pending", {28'd0, irq_pending}, 32'h8);
    step(2);
    check("t2_ch3_blocked", {31'd0, irq_req}, 32'd0);
    expect_req(2'd3, 16'h0010, 2);
    do_eoi();
    check("t2_eoi", {28'd0, irq_in_service}, 32'd0);
    step();
    do_ack(4'b1000, 4'b1000);
    do_eoi();
    check("t2_eoi2", {28'd0, irq_in_service}, 32'd0);
    irq_in = 4'b0000;
    step();

    // Nesting: channel 2 in service, then channel 0
    irq_in[2] = 1'b1;
    expect_req(2'd2, 16'h000C, 2);
    step(2);
    do_ack(4'b0100, 4'b0100);
    irq_in[0] = 1'b1;
    expect_req(2'd0, 16'h0004, 2);
    step(2);
    do_ack(4'b0001, 4'b0101);
    check("t3_nested", {28'd0, irq_in_service}, 32'h5);
    irq_eoi = 1'b1;
    step();
    check("t3_eoi1", {28'd0, irq_in_service}, 32'h4);
    step();
    check("t3_eoi2", {28'd0, irq_in_service}, 32'h0);
    step();
    check("t3_eoi3_empty", {28'd0, irq_in_service}, 32'h0);
    check("t3_inactive", {31'd0, irq_active}, 32'd0);
    irq_eoi = 1'b0;
    irq_in = 4'b0000;
    step();

    // Withdrawal by masking channel 1 while in REQ
    irq_in[1] = 1'b1;
    expect_req(2'd1, 16'h0008, 2);
    step(2);
    check("t4_in_req", {31'd0, irq_req}, 32'd1);
    irq_mask = 4'b1101;
    step();
    check("t4_withdrawn", {31'd0, irq_req}, 32'd0);
    check("t4_no_clr", {28'd0, irq_clr}, 32'd0);
    check("t4_is_unchanged", {28'd0, irq_in_service}, 32'd0);
    check("t4_still_pending", {28'd0, irq_pending}, 32'h2);
    irq_mask = 4'hF;
    expect_req(2'd1, 16'h0008, 1);
    step();
    do_ack(4'b0010, 4'b0010);
    do_eoi();
    irq_in = 4'b0000;
    step();

    // Level channel 3 gated by global_ie, then line dropped before ack
    irq_edge_mode = 4'b0111;
    global_ie = 1'b0;
    irq_in[3] = 1'b1;
    step(4);
    check("t5_no_req_ie0", {31'd0, irq_req}, 32'd0);
    check("t5_level_pending", {28'd0, irq_pending}, 32'h8);
    global_ie = 1'b1;
    expect_req(2'd3, 16'h0010, 1);
    step();
    irq_in[3] = 1'b0;
    step(2);
    check("t5_withdrawn", {31'd0, irq_req}, 32'd0);
    check("t5_pending_gone", {28'd0, irq_pending}, 32'h0);
    check("t5_is_unchanged", {28'd0, irq_in_service}, 32'd0);
    irq_edge_mode = 4'hF;
    step();

    // Reset while in REQ with channel 0 held high
    irq_in = 4'b0001;
    expect_req(2'd0, 16'h0004, 2);
    step(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_req", {31'd0, irq_req}, 32'd0);
    check("t6_rst_id", {30'd0, irq_id}, 32'd0);
    check("t6_rst_vector", {16'd0, irq_vector}, 32'h0004);
    check("t6_rst_pending", {28'd0, irq_pending}, 32'd0);
    step(3);
    check("t6_no_req_after", {31'd0, irq_req}, 32'd0);
    check("t6_no_pending_after", {28'd0, irq_pending}, 32'd0);
    irq_in = 4'b0000;
    step();
    irq_in = 4'b0001;
    expect_req(2'd0, 16'h0004, 2);
    step(2);
    do_ack(4'b0001, 4'b0001);
    do_eoi();
    check("t6_eoi", {28'd0, irq_in_service}, 32'd0);
    irq_in = 4'b0000;
    step(3);

    check("req_queue_drained", exp_req_q.size(), 32'd0);
    check("ack_queue_drained", exp_ack_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
